// File: rtl/jtag_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jtag_pkg
// Description : Shared definitions for the JTAG TAP driver: 1149.1 TAP state
//               codes, driver FSM encoding and the TAP next-state function.
// Revision    : 1.0 - initial release
// ============================================================================
package jtag_pkg;

   localparam int FSM_SIZE = 4;

   // IEEE 1149.1 TAP controller state codes
   localparam logic [FSM_SIZE-1:0] c_TAP_TLR      = 4'hF;
   localparam logic [FSM_SIZE-1:0] c_TAP_RTI      = 4'hC;
   localparam logic [FSM_SIZE-1:0] c_TAP_SEL_DR   = 4'h7;
   localparam logic [FSM_SIZE-1:0] c_TAP_CAP_DR   = 4'h6;
   localparam logic [FSM_SIZE-1:0] c_TAP_SHIFT_DR = 4'h2;
   localparam logic [FSM_SIZE-1:0] c_TAP_EXIT1_DR = 4'h1;
   localparam logic [FSM_SIZE-1:0] c_TAP_PAUSE_DR = 4'h3;
   localparam logic [FSM_SIZE-1:0] c_TAP_EXIT2_DR = 4'h0;
   localparam logic [FSM_SIZE-1:0] c_TAP_UPD_DR   = 4'h5;
   localparam logic [FSM_SIZE-1:0] c_TAP_SEL_IR   = 4'h4;
   localparam logic [FSM_SIZE-1:0] c_TAP_CAP_IR   = 4'hE;
   localparam logic [FSM_SIZE-1:0] c_TAP_SHIFT_IR = 4'hA;
   localparam logic [FSM_SIZE-1:0] c_TAP_EXIT1_IR = 4'h9;
   localparam logic [FSM_SIZE-1:0] c_TAP_PAUSE_IR = 4'hB;
   localparam logic [FSM_SIZE-1:0] c_TAP_EXIT2_IR = 4'h8;
   localparam logic [FSM_SIZE-1:0] c_TAP_UPD_IR   = 4'hD;

   // Driver sequencing states
   typedef enum logic [1:0] {
      DRV_RESET_SEQ = 2'd0,
      DRV_IDLE      = 2'd1,
      DRV_SCAN      = 2'd2
   } drv_state_t;

   // Standard TAP transition for the given TMS value
   function automatic logic [FSM_SIZE-1:0] tap_next(input logic [FSM_SIZE-1:0] s,
                                                    input logic tms);
      logic [FSM_SIZE-1:0] n;
      n = c_TAP_TLR;
      case (s)
         c_TAP_TLR      : n = tms ? c_TAP_TLR      : c_TAP_RTI;
         c_TAP_RTI      : n = tms ? c_TAP_SEL_DR   : c_TAP_RTI;
         c_TAP_SEL_DR   : n = tms ? c_TAP_SEL_IR   : c_TAP_CAP_DR;
         c_TAP_CAP_DR   : n = tms ? c_TAP_EXIT1_DR : c_TAP_SHIFT_DR;
         c_TAP_SHIFT_DR : n = tms ? c_TAP_EXIT1_DR : c_TAP_SHIFT_DR;
         c_TAP_EXIT1_DR : n = tms ? c_TAP_UPD_DR   : c_TAP_PAUSE_DR;
         c_TAP_PAUSE_DR : n = tms ? c_TAP_EXIT2_DR : c_TAP_PAUSE_DR;
         c_TAP_EXIT2_DR : n = tms ? c_TAP_UPD_DR   : c_TAP_SHIFT_DR;
         c_TAP_UPD_DR   : n = tms ? c_TAP_SEL_DR   : c_TAP_RTI;
         c_TAP_SEL_IR   : n = tms ? c_TAP_TLR      : c_TAP_CAP_IR;
         c_TAP_CAP_IR   : n = tms ? c_TAP_EXIT1_IR : c_TAP_SHIFT_IR;
         c_TAP_SHIFT_IR : n = tms ? c_TAP_EXIT1_IR : c_TAP_SHIFT_IR;
         c_TAP_EXIT1_IR : n = tms ? c_TAP_UPD_IR   : c_TAP_PAUSE_IR;
         c_TAP_PAUSE_IR : n = tms ? c_TAP_EXIT2_IR : c_TAP_PAUSE_IR;
         c_TAP_EXIT2_IR : n = tms ? c_TAP_UPD_IR   : c_TAP_SHIFT_IR;
         c_TAP_UPD_IR   : n = tms ? c_TAP_SEL_DR   : c_TAP_RTI;
         default        : n = c_TAP_TLR;
      endcase
      return n;
   endfunction

endpackage : jtag_pkg
`default_nettype wire

// File: rtl/jtag_tap_shadow.sv
`default_nettype none
// ============================================================================
// Module      : jtag_tap_shadow
// Description : TAP controller state register. Tracks the target TAP state
//               from TMS on the shared TCK; also usable as a bench reference.
// Revision    : 1.0 - initial release
// ============================================================================
module jtag_tap_shadow
   import jtag_pkg::*;
(
   input  logic                TCK,
   input  logic                TRST,
   input  logic                TMS,
   output logic [FSM_SIZE-1:0] state
);

   // Advance one TAP transition per TCK edge; TRST forces Test-Logic-Reset
   always_ff @(posedge TCK) begin
      if (TRST) begin
         state <= c_TAP_TLR;
      end else begin
         state <= tap_next(state, TMS);
      end
   end

endmodule : jtag_tap_shadow
`default_nettype wire

// File: rtl/jtag_tap_driver.sv
`default_nettype none
// ============================================================================
// Module      : jtag_tap_driver
// Description : JTAG initiator. Runs a TAP reset sequence, then accepts single
//               IR/DR scan commands and generates registered TMS/TDI, returning
//               the TDO bits shifted out. Keeps a shadow copy of the TAP state.
// Config      : JTAG_TDO_CAPTURE_EN - when defined, TDO is captured into
//               data_out; otherwise data_out is constant 0.
// Revision    : 1.0 - initial release
// ============================================================================
module jtag_tap_driver
   import jtag_pkg::*;
#(
   parameter int MAX_LEN = 32,
   parameter int LEN_W   = 6
)(
   input  logic                TCK,
   input  logic                TRST,
   input  logic                start,
   input  logic                is_ir,
   input  logic [LEN_W-1:0]    len,
   input  logic [MAX_LEN-1:0]  data_in,
   input  logic                TDO,
   output logic                TMS,
   output logic                TDI,
   output logic                busy,
   output logic                done,
   output logic [MAX_LEN-1:0]  data_out,
   output logic [FSM_SIZE-1:0] tap_state
);

   localparam logic [LEN_W-1:0] c_MAX_LEN = LEN_W'(MAX_LEN);

   drv_state_t          r_drv;
   logic                r_is_ir;
   logic [LEN_W-1:0]    r_len;
   logic [LEN_W-1:0]    r_cnt;
   logic [MAX_LEN-1:0]  r_din;

   logic [FSM_SIZE-1:0] w_nxt;
   logic                w_in_shift;
   logic [LEN_W-1:0]    w_idx;
   logic                w_last;
   logic                w_cmd_ok;

   jtag_tap_shadow u_shadow (
      .TCK   (TCK),
      .TRST  (TRST),
      .TMS   (TMS),
      .state (tap_state)
   );

   // The TMS/TDI registered now are seen by the TAP at the next edge, so
   // decisions are made on the state the TAP enters at this edge (w_nxt).
   assign w_nxt      = tap_next(tap_state, TMS);
   assign w_in_shift = (tap_state == c_TAP_SHIFT_DR) || (tap_state == c_TAP_SHIFT_IR);
   // Index of the shift bit the coming edge will perform
   assign w_idx      = r_cnt + LEN_W'(w_in_shift);
   assign w_last     = (w_idx == (r_len - LEN_W'(1)));
   assign w_cmd_ok   = start && (len != '0) && (len <= c_MAX_LEN);

   // Driver FSM: reset sequence, idle in RTI, scan walk back to RTI
   always_ff @(posedge TCK) begin
      if (TRST) begin
         r_drv   <= DRV_RESET_SEQ;
         TMS     <= 1'b1;
         TDI     <= 1'b0;
         busy    <= 1'b1;
         done    <= 1'b0;
         r_cnt   <= '0;
         r_is_ir <= 1'b0;
         r_len   <= '0;
         r_din   <= '0;
      end else begin
         done <= 1'b0;
         case (r_drv)
            DRV_RESET_SEQ: begin
               // Five edges of TMS=1 hold TLR, one edge of TMS=0 enters RTI
               r_cnt <= r_cnt + LEN_W'(1);
               if (r_cnt == LEN_W'(4)) begin
                  TMS <= 1'b0;
               end
               if (r_cnt == LEN_W'(5)) begin
                  r_drv <= DRV_IDLE;
                  busy  <= 1'b0;
               end
            end
            DRV_IDLE: begin
               TMS <= 1'b0;
               TDI <= 1'b0;
               if (w_cmd_ok) begin
                  r_is_ir <= is_ir;
                  r_len   <= len;
                  r_din   <= data_in;
                  r_cnt   <= '0;
                  TMS     <= 1'b1;
                  busy    <= 1'b1;
                  r_drv   <= DRV_SCAN;
               end
            end
            DRV_SCAN: begin
               if (w_in_shift) begin
                  r_cnt <= r_cnt + LEN_W'(1);
                  r_din <= r_din >> 1;
               end
               TDI <= 1'b0;
               case (w_nxt)
                  c_TAP_SEL_DR   : TMS <= r_is_ir;
                  c_TAP_SEL_IR,
                  c_TAP_CAP_DR,
                  c_TAP_CAP_IR   : TMS <= 1'b0;
                  c_TAP_SHIFT_DR,
                  c_TAP_SHIFT_IR : begin
                     TMS <= w_last;
                     // r_din shifts at this edge when already shifting
                     TDI <= w_in_shift ? r_din[1] : r_din[0];
                  end
                  c_TAP_EXIT1_DR,
                  c_TAP_EXIT1_IR : TMS <= 1'b1;
                  c_TAP_UPD_DR,
                  c_TAP_UPD_IR   : TMS <= 1'b0;
                  c_TAP_RTI      : begin
                     TMS   <= 1'b0;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     r_drv <= DRV_IDLE;
                  end
                  default        : TMS <= 1'b0;
               endcase
            end
            default: r_drv <= DRV_RESET_SEQ;
         endcase
      end
   end

`ifdef JTAG_TDO_CAPTURE_EN
   logic [MAX_LEN-1:0] r_cap;
   // No TRST clear: an aborted scan leaves the previous result visible
   logic [MAX_LEN-1:0] r_dout = '0;
   logic               w_finish;

   assign w_finish = (r_drv == DRV_SCAN) && (w_nxt == c_TAP_RTI);

   // TDO enters at the MSB so the first bit lands at the LSB after alignment
   always_ff @(posedge TCK) begin
      if (TRST) begin
         r_cap <= '0;
      end else if ((r_drv == DRV_IDLE) && w_cmd_ok) begin
         r_cap <= '0;
      end else if ((r_drv == DRV_SCAN) && w_in_shift) begin
         r_cap <= {TDO, r_cap[MAX_LEN-1:1]};
      end
   end

   // Right-align the captured bits on return to RTI
   always_ff @(posedge TCK) begin
      if (!TRST && w_finish) begin
         r_dout <= r_cap >> (c_MAX_LEN - r_len);
      end
   end

   assign data_out = r_dout;
`else
   logic w_unused_tdo;
   assign w_unused_tdo = TDO;
   assign data_out     = '0;
`endif

endmodule : jtag_tap_driver
`default_nettype wire

// File: tb/tb_jtag_tap_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_jtag_tap_driver
// Description : Scoreboard bench for jtag_tap_driver. Scans push their expected
//               TMS/state/TDI/data_out record; a negedge monitor pops and
//               compares whenever done pulses. TDO is looped back from TDI.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jtag_tap_driver;

   logic        TCK = 1'b0;
   logic        TRST;
   logic        start;
   logic        is_ir;
   logic [5:0]  len;
   logic [31:0] data_in;
   logic        TDO;
   logic        TMS;
   logic        TDI;
   logic        busy;
   logic        done;
   logic [31:0] data_out;
   logic [3:0]  tap_state;

   assign TDO = TDI;

   jtag_tap_driver #(.MAX_LEN(32), .LEN_W(6)) dut (
      .TCK       (TCK),
      .TRST      (TRST),
      .start     (start),
      .is_ir     (is_ir),
      .len       (len),
      .data_in   (data_in),
      .TDO       (TDO),
      .TMS       (TMS),
      .TDI       (TDI),
      .busy      (busy),
      .done      (done),
      .data_out  (data_out),
      .tap_state (tap_state)
   );

   initial forever #5 TCK = ~TCK;

   int n_run  = 0;
   int n_fail = 0;

   typedef struct {
      int                n;
      logic [39:0]       tms;
      logic [39:0][3:0]  st;
      int                len;
      logic [31:0]       din;
      logic [31:0]       dout;
   } exp_t;

   exp_t        q[$];
   logic [31:0] last_dout = '0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] lmask(input int l);
      logic [31:0] one;
      one = 32'h1;
      return (l >= 32) ? 32'hFFFF_FFFF : ((one << l) - one);
   endfunction

   // Expected TMS and pre-edge TAP state for each edge of a scan
   function automatic exp_t build(input bit ir, input int l, input logic [31:0] din);
      exp_t e;
      int   k;
      k = 0;
      e.tms = '0; e.st = '0; e.len = l; e.din = din;
      e.tms[k] = 1'b1; e.st[k] = 4'hC; k++;
      if (ir) begin
         e.tms[k] = 1'b1; e.st[k] = 4'h7; k++;
         e.tms[k] = 1'b0; e.st[k] = 4'h4; k++;
         e.tms[k] = 1'b0; e.st[k] = 4'hE; k++;
      end else begin
         e.tms[k] = 1'b0; e.st[k] = 4'h7; k++;
         e.tms[k] = 1'b0; e.st[k] = 4'h6; k++;
      end
      for (int i = 0; i < l; i++) begin
         e.tms[k] = (i == l - 1); e.st[k] = ir ? 4'hA : 4'h2; k++;
      end
      e.tms[k] = 1'b1; e.st[k] = ir ? 4'h9 : 4'h1; k++;
      e.tms[k] = 1'b0; e.st[k] = ir ? 4'hD : 4'h5; k++;
      e.n = k;
`ifdef JTAG_TDO_CAPTURE_EN
      e.dout = din & lmask(l);
`else
      e.dout = 32'h0;
`endif
      return e;
   endfunction

   // ---------------- monitor ----------------
   bit               mon_ready = 1'b0;
   int               obs_n, obs_tdi_n, obs_tdi_junk;
   logic [39:0]      obs_tms;
   logic [39:0][3:0] obs_st;
   logic [31:0]      obs_tdi;

   always @(negedge TCK) begin
      if (TRST) begin
         mon_ready = 1'b0;
         obs_n = 0; obs_tdi_n = 0; obs_tdi_junk = 0;
         obs_tms = '0; obs_st = '0; obs_tdi = '0;
      end else if (busy) begin
         if (mon_ready && obs_n < 40) begin
            obs_tms[obs_n] = TMS;
            obs_st[obs_n]  = tap_state;
            obs_n++;
            if (tap_state == 4'h2 || tap_state == 4'hA) begin
               if (obs_tdi_n < 32) obs_tdi[obs_tdi_n] = TDI;
               obs_tdi_n++;
            end else if (TDI !== 1'b0) begin
               obs_tdi_junk++;
            end
         end
      end else begin
         if (done) begin
            if (q.size() == 0) begin
               n_run++; n_fail++;
               $display("FAIL extra_done: got done=1, expected no done (no command pending)");
            end else begin
               exp_t e;
               e = q.pop_front();
               check("edge_count", obs_n, e.n);
               check("tms_seq", obs_tms, e.tms);
               check("state_seq", obs_st, e.st);
               check("tdi_count", obs_tdi_n, e.len);
               check("tdi_bits", obs_tdi & lmask(e.len), e.din & lmask(e.len));
               check("tdi_outside_shift", obs_tdi_junk, 0);
               check("data_out", data_out, e.dout);
               check("done_state", tap_state, 4'hC);
               last_dout = e.dout;
            end
            obs_n = 0; obs_tdi_n = 0; obs_tdi_junk = 0;
            obs_tms = '0; obs_st = '0; obs_tdi = '0;
         end else if (mon_ready) begin
            check("idle_tms", {TMS, TDI}, 2'b00);
         end
         mon_ready = 1'b1;
      end
   end

   // ---------------- stimulus ----------------
   task automatic do_reset(input int cycles);
      logic [5:0] tv, bv;
      TRST = 1'b1;
      start = 1'b0;
      repeat (cycles) @(negedge TCK);
      check("rst_outputs", {TMS, TDI, busy, done, tap_state}, {1'b1, 1'b0, 1'b1, 1'b0, 4'hF});
      TRST = 1'b0;
      for (int k = 0; k < 6; k++) begin
         tv[k] = TMS;
         bv[k] = busy;
         @(negedge TCK);
      end
      check("rst_tms_seq", tv, 6'b011111);
      check("rst_busy_seq", bv, 6'b111111);
      check("rst_end", {busy, done, tap_state}, {1'b0, 1'b0, 4'hC});
      check("rst_data_out", data_out, last_dout);
   endtask

   // Issue one scan at the current negedge and wait for its done pulse.
   task automatic scan(input bit ir, input int l, input logic [31:0] din,
                       input logic [39:0] tms_lit, input bit use_lit, input int noise_at);
      exp_t e;
      int   t;
      e = build(ir, l, din);
      if (use_lit) e.tms = tms_lit;
      q.push_back(e);
      start = 1'b1; is_ir = ir; len = 6'(l); data_in = din;
      @(negedge TCK);
      start = 1'b0;
      t = 0;
      while (!done && t < 100) begin
         if (t == noise_at) begin
            start = 1'b1; is_ir = 1'b1; len = 6'd8; data_in = 32'hFFFF_FFFF;
         end else begin
            start = 1'b0;
         end
         @(negedge TCK);
         t++;
      end
      start = 1'b0;
      check("done_latency", t, e.n);
   endtask

   task automatic ignored(input int l);
      logic [3:0] bv;
      start = 1'b1; is_ir = 1'b0; len = 6'(l); data_in = 32'h1234_5678;
      @(negedge TCK);
      start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         bv[k] = busy;
         @(negedge TCK);
      end
      check("ignored_busy", bv, 4'b0000);
   endtask

   initial begin
      TRST = 1'b1; start = 1'b0; is_ir = 1'b0; len = '0; data_in = '0;
      @(negedge TCK);
      do_reset(2);

      // DR len 8, TMS 1,0,0,0x7,1,1,0
      scan(1'b0, 8, 32'h0000_00A5, 40'h0C01, 1'b1, -1);
      // IR len 4, TMS 1,1,0,0,0,0,0,1,1,0
      scan(1'b1, 4, 32'h0000_0003, 40'h183, 1'b1, -1);

      ignored(0);
      ignored(33);

      // start while busy must be ignored
      scan(1'b0, 4, 32'h0000_0009, '0, 1'b0, 3);
      repeat (4) @(negedge TCK);

      // back-to-back commands, including minimum length
      scan(1'b0, 1, 32'h0000_0001, '0, 1'b0, -1);
      scan(1'b1, 5, 32'h0000_0015, '0, 1'b0, -1);
      scan(1'b0, 8, 32'h0000_00C3, '0, 1'b0, -1);

      // abort mid-shift after 3 of 8 bits
      start = 1'b1; is_ir = 1'b0; len = 6'd8; data_in = 32'h0000_005A;
      @(negedge TCK);
      start = 1'b0;
      begin
         int t;
         t = 0;
         while (tap_state != 4'h2 && t < 20) begin
            @(negedge TCK);
            t++;
         end
         check("abort_reach_shift", tap_state, 4'h2);
      end
      repeat (3) @(negedge TCK);
      do_reset(2);

      // max length scans
      scan(1'b0, 32, 32'hFFFF_0001, '0, 1'b0, -1);
      scan(1'b1, 32, 32'h8000_0001, '0, 1'b0, -1);
      scan(1'b0, 8, 32'h0000_005A, '0, 1'b0, -1);

      repeat (5) @(negedge TCK);
      check("queue_empty", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, expected completion");
      $fatal(1, "watchdog");
   end

endmodule : tb_jtag_tap_driver
`default_nettype wire
